prog_mem_loader: RTL and testbench

- Parametrised program memory with an auto-incrementing burst loader port and a handshaked instruction-fetch port.
- Sits between the boot/debug loader and the core fetch stage.
- Tracks per-word written status so fetches from unloaded locations are flagged, in synthesisable form.
- Read latency is selectable for timing closure.

---
 rtl/prog_mem_loader.sv | 183 ++++++++++++++++++
 tb/tb_prog_mem_loader.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_mem_loader.sv
`default_nettype none
// =============================================================================
// prog_mem_loader : program memory with auto-incrementing burst loader and
//                   handshaked fetch port with per-word "loaded" tracking.
// Rev 1.0
// =============================================================================
module prog_mem_loader #(
    parameter int DATA_SIZE    = 16,
    parameter int ADDR_SIZE    = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 load_start,
    input  logic [ADDR_SIZE-1:0] load_base,
    input  logic [ADDR_SIZE:0]   load_len,
    input  logic                 load_valid,
    input  logic [DATA_SIZE-1:0] load_data,
    output logic                 load_ready,
    output logic                 load_busy,
    output logic                 load_done,
    input  logic                 fetch_req,
    input  logic [ADDR_SIZE-1:0] fetch_addr,
    output logic                 fetch_ready,
    output logic                 fetch_valid,
    output logic [DATA_SIZE-1:0] fetch_data,
    output logic                 fetch_err
);
    localparam int                 DEPTH   = 2**ADDR_SIZE;
    localparam logic [ADDR_SIZE:0] CNT_ONE = (ADDR_SIZE+1)'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   ptr_q, ptr_d;
    logic [ADDR_SIZE:0]     cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   wr_en;
    logic [DEPTH-1:0]       written_q;
    logic [DATA_SIZE-1:0]   mem [DEPTH];
    logic                   fetch_acc;
    logic [DATA_SIZE-1:0]   rd_data;
    logic                   rd_err;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        load_ready  = 1'b0;
        load_busy   = 1'b0;
        fetch_ready = 1'b0;
        case (state_q)
            S_IDLE: begin
                fetch_ready = 1'b1;
                if (load_start) begin
                    ptr_d = load_base;
                    cnt_d = load_len;
                    if (load_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                load_ready = 1'b1;
                load_busy  = 1'b1;
                if (load_valid) begin
                    wr_en = 1'b1;
                    ptr_d = ptr_q + 1'b1;   // wraps modulo DEPTH
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_ONE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign load_done = done_q;

    // Contents deliberately survive reset; only the written-bits are cleared.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[ptr_q] <= load_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            written_q <= '0;
        end else if (wr_en) begin
            written_q[ptr_q] <= 1'b1;
        end
    end

    // Fetches are only accepted in IDLE, where no write can collide.
    assign fetch_acc = fetch_req & fetch_ready;
    assign rd_data   = mem[fetch_addr];
    assign rd_err    = ~written_q[fetch_addr];

    generate
        if (READ_LATENCY == 1) begin : g_lat1
            logic                 valid_q;
            logic [DATA_SIZE-1:0] data_q;
            logic                 err_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                    err_q   <= 1'b0;
                end else begin
                    valid_q <= fetch_acc;
                    if (fetch_acc) begin
                        data_q <= rd_data;
                        err_q  <= rd_err;
                    end
                end
            end

            assign fetch_valid = valid_q;
            assign fetch_data  = data_q;
            assign fetch_err   = err_q;
        end else if (READ_LATENCY == 2) begin : g_lat2
            logic                 s1_valid_q, s2_valid_q;
            logic [DATA_SIZE-1:0] s1_data_q,  s2_data_q;
            logic                 s1_err_q,   s2_err_q;

            // Array is sampled at acceptance so a later load cannot alter the result.
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    s1_valid_q <= 1'b0;
                    s1_data_q  <= '0;
                    s1_err_q   <= 1'b0;
                    s2_valid_q <= 1'b0;
                    s2_data_q  <= '0;
                    s2_err_q   <= 1'b0;
                end else begin
                    s1_valid_q <= fetch_acc;
                    if (fetch_acc) begin
                        s1_data_q <= rd_data;
                        s1_err_q  <= rd_err;
                    end
                    s2_valid_q <= s1_valid_q;
                    if (s1_valid_q) begin
                        s2_data_q <= s1_data_q;
                        s2_err_q  <= s1_err_q;
                    end
                end
            end

            assign fetch_valid = s2_valid_q;
            assign fetch_data  = s2_data_q;
            assign fetch_err   = s2_err_q;
        end else begin : g_bad_latency
            $error("prog_mem_loader: READ_LATENCY must be 1 or 2");
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_prog_mem_loader.sv
`default_nettype none
// tb_prog_mem_loader : directed + random stimulus driving latency-1 and latency-2
// instances in parallel, checked against a word-level memory model.
module tb_prog_mem_loader;
    localparam int DW    = 16;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          load_start = 1'b0;
    logic [AW-1:0] load_base = '0;
    logic [AW:0]   load_len = '0;
    logic          load_valid = 1'b0;
    logic [DW-1:0] load_data = '0;
    logic          fetch_req = 1'b0;
    logic [AW-1:0] fetch_addr = '0;

    logic          rdy1, busy1, done1, frdy1, fv1, fe1;
    logic [DW-1:0] fd1;
    logic          rdy2, busy2, done2, frdy2, fv2, fe2;
    logic [DW-1:0] fd2;

    always #5 clk = ~clk;

    prog_mem_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .READ_LATENCY(1)) u_dut1 (
        .clk(clk), .rstn(rstn),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy1), .load_busy(busy1), .load_done(done1),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(frdy1), .fetch_valid(fv1), .fetch_data(fd1), .fetch_err(fe1)
    );

    prog_mem_loader #(.DATA_SIZE(DW), .ADDR_SIZE(AW), .READ_LATENCY(2)) u_dut2 (
        .clk(clk), .rstn(rstn),
        .load_start(load_start), .load_base(load_base), .load_len(load_len),
        .load_valid(load_valid), .load_data(load_data),
        .load_ready(rdy2), .load_busy(busy2), .load_done(done2),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(frdy2), .fetch_valid(fv2), .fetch_data(fd2), .fetch_err(fe2)
    );

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem   [DEPTH];
    bit            m_known [DEPTH];   // contents predictable (survives reset)
    bit            m_wr    [DEPTH];   // written since reset
    bit            m_loading;
    int            m_ptr, m_left;
    bit            e_done;
    bit            e_v [1:2];
    logic [DW-1:0] e_d [1:2];
    bit            e_k [1:2];
    bit            e_e [1:2];
    bit            p_v, p_k, p_e;
    logic [DW-1:0] p_d;
    bit            n_v, n_k, n_e;
    logic [DW-1:0] n_d;

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) m_wr[i] = 1'b0;
            m_loading = 1'b0;
            m_ptr     = 0;
            m_left    = 0;
            e_done    = 1'b0;
            for (int l = 1; l <= 2; l++) begin
                e_v[l] = 1'b0; e_d[l] = '0; e_k[l] = 1'b1; e_e[l] = 1'b0;
            end
            p_v = 1'b0;
        end else begin
            n_v = fetch_req && !m_loading;
            n_d = m_mem[fetch_addr];
            n_k = m_known[fetch_addr];
            n_e = !m_wr[fetch_addr];
            e_v[2] = p_v;
            if (p_v) begin e_d[2] = p_d; e_k[2] = p_k; e_e[2] = p_e; end
            p_v = n_v; p_d = n_d; p_k = n_k; p_e = n_e;
            e_v[1] = n_v;
            if (n_v) begin e_d[1] = n_d; e_k[1] = n_k; e_e[1] = n_e; end
            e_done = 1'b0;
            if (!m_loading) begin
                if (load_start) begin
                    if (load_len == 0) begin
                        e_done = 1'b1;
                    end else begin
                        m_loading = 1'b1;
                        m_ptr     = int'(load_base);
                        m_left    = int'(load_len);
                    end
                end
            end else if (load_valid) begin
                m_mem[m_ptr]   = load_data;
                m_known[m_ptr] = 1'b1;
                m_wr[m_ptr]    = 1'b1;
                m_ptr          = (m_ptr + 1) % DEPTH;
                m_left         = m_left - 1;
                if (m_left == 0) begin
                    m_loading = 1'b0;
                    e_done    = 1'b1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_dut(input int l, input logic rdy, input logic busy, input logic done,
                             input logic frdy, input logic fv, input logic fe,
                             input logic [DW-1:0] fd);
        string s;
        s = $sformatf("L%0d", l);
        chk({s, ".load_ready"},  32'(rdy),  32'(m_loading));
        chk({s, ".load_busy"},   32'(busy), 32'(m_loading));
        chk({s, ".load_done"},   32'(done), 32'(e_done));
        chk({s, ".fetch_ready"}, 32'(frdy), 32'(!m_loading));
        chk({s, ".fetch_valid"}, 32'(fv),   32'(e_v[l]));
        if (e_v[l]) chk({s, ".fetch_err"}, 32'(fe), 32'(e_e[l]));
        if (e_k[l]) chk({s, ".fetch_data"}, 32'(fd), 32'(e_d[l]));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        check_dut(1, rdy1, busy1, done1, frdy1, fv1, fe1, fd1);
        check_dut(2, rdy2, busy2, done2, frdy2, fv2, fe2, fd2);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic reset_now();
        #2 rstn = 1'b0;
        #1;
        chk("rst.load_ready1", 32'(rdy1), 0);
        chk("rst.load_busy1",  32'(busy1), 0);
        chk("rst.load_done1",  32'(done1), 0);
        chk("rst.fetch_valid1", 32'(fv1), 0);
        chk("rst.fetch_data1", 32'(fd1), 0);
        chk("rst.load_ready2", 32'(rdy2), 0);
        chk("rst.load_done2",  32'(done2), 0);
        chk("rst.fetch_valid2", 32'(fv2), 0);
        chk("rst.fetch_data2", 32'(fd2), 0);
        tick();
        rstn = 1'b1;
    endtask

    task automatic start_load(input int base, input int len);
        load_start = 1'b1;
        load_base  = AW'(base);
        load_len   = (AW+1)'(len);
        tick();
        load_start = 1'b0;
    endtask

    task automatic beat(input logic [DW-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic fetch_run(input int first, input int n);
        for (int i = 0; i < n; i++) begin
            fetch_req  = 1'b1;
            fetch_addr = AW'(first + i);
            tick();
        end
        fetch_req = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        logic [DW-1:0] wrap_words [4];
        wrap_words = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD};

        tick();
        rstn = 1'b1;
        tick();

        fetch_run(3, 1);                               // unloaded word flags error

        start_load(0, 4);                              // gapless burst
        beat(16'h1111); beat(16'h2222); beat(16'h3333); beat(16'h4444);
        tick();
        fetch_run(0, 4);

        start_load(14, 4);                             // wrap + stalls + ignored start/fetch
        for (int i = 0; i < 4; i++) begin
            beat(wrap_words[i]);
            if (i < 3) begin
                fetch_req  = 1'b1;
                fetch_addr = 4'd5;
                load_start = 1'b1;
                load_base  = 4'd7;
                load_len   = 5'd2;
                tick();
                fetch_req  = 1'b0;
                load_start = 1'b0;
            end
        end
        tick();
        fetch_run(14, 5);

        start_load(9, 0);                              // zero-length burst
        tick();
        fetch_run(9, 1);

        fetch_req  = 1'b1;                             // same-cycle start and fetch
        fetch_addr = 4'd0;
        start_load(0, 1);
        fetch_req  = 1'b0;
        beat(16'hBEEF);
        tick();
        fetch_run(0, 1);

        start_load(4, 4);                              // reset mid-burst
        beat(16'h5555); beat(16'h6666);
        reset_now();
        tick();
        tick();
        fetch_run(0, 16);

        for (int c = 0; c < 1500; c++) begin
            load_start = ($urandom_range(0, 9) == 0);
            load_base  = AW'($urandom_range(0, 15));
            load_len   = (AW+1)'($urandom_range(0, 16));
            load_valid = 1'($urandom_range(0, 1));
            load_data  = DW'($urandom);
            fetch_req  = 1'($urandom_range(0, 1));
            fetch_addr = AW'($urandom_range(0, 15));
            if ($urandom_range(0, 299) == 0) reset_now();
            else tick();
        end
        load_start = 1'b0;
        load_valid = 1'b0;
        fetch_req  = 1'b0;
        tick();
        tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
